sdram_port_arbiter: RTL and testbench
=====================================

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of requester ports (2..4).
REQ-002 SHALL have parameter TIMEOUT, default 255: watchdog cycles allowed from mem_req to mem_ready.
REQ-003 SHALL have port clk, input, 1: single clock (clk_base domain, ~33 MHz); the block uses one clock; reset is synchronous and active-high.
REQ-004 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-005 SHALL have port rq_req, input, NUM_REQ: per-requester one-cycle request strobe.
REQ-006 SHALL have port rq_addr, input, NUM_REQ x 27: byte address; bit 26 selects the chip.
REQ-007 SHALL have port rq_din, input, NUM_REQ x 32: write data.
REQ-008 SHALL have port rq_be, input, NUM_REQ x 4: byte enables, active-high.
REQ-009 SHALL have port rq_rnw, input, NUM_REQ: 1 = read, 0 = write.
REQ-010 SHALL have port rq_done, output, NUM_REQ: one-cycle completion strobe.
REQ-011 SHALL have port rq_dout, output, 32: read data, shared, valid in the rq_done cycle.
REQ-012 SHALL have port mem_req, mem_addr[26:0], mem_din[31:0], mem_be[3:0], mem_rnw, outputs: request to one 32-bit SDRAM channel.
REQ-013 SHALL have port mem_ready, input, 1 (one-cycle strobe), and mem_dout, input, 32: channel completion and read data.
REQ-014 SHALL have port err_overrun, output, NUM_REQ, and err_timeout, output, 1: sticky error flags.

Function
REQ-015 A strobe on rq_req[i] SHALL set pending[i] and latch addr/din/be/rnw into slot i in the same edge.
- If pending[i] is already set, the strobe SHALL be dropped and err_overrun[i] set.
REQ-016 The FSM SHALL have three states: IDLE, ISSUE, WAIT.
REQ-017 IDLE, with any pending bit set: SHALL select a winner per REQ-026 and go to ISSUE.
REQ-018 ISSUE SHALL last exactly 1 cycle.
- mem_req=1; mem_* driven from the winner's slot.
- Next state is WAIT; the watchdog is loaded with TIMEOUT.
REQ-019 mem_* fields SHALL be held stable from ISSUE until the exit from WAIT.
- mem_req SHALL be 0 in all other cycles.
REQ-020 WAIT, on mem_ready: the next cycle SHALL assert rq_done[winner] for 1 cycle.
- In that cycle rq_dout SHALL equal the registered mem_dout for reads and 0 for writes.
- pending[winner] SHALL clear and the FSM returns to IDLE.
REQ-021 WAIT, watchdog reaching 0 without mem_ready:
- SHALL complete as REQ-020 with rq_dout=32'hFFFFFFFF and set err_timeout.
- A late mem_ready outside WAIT SHALL be ignored.
REQ-022 Latency SHALL be fixed: rq_req strobe to mem_req = 2 cycles when idle; mem_ready to rq_done = 1 cycle.
REQ-023 rq_req[winner] arriving in its own rq_done cycle SHALL be accepted, since pending clears first.
- Minimum back-to-back spacing is 3 cycles.
REQ-024 At most one transaction SHALL be outstanding.
- Strobes from other requesters during ISSUE/WAIT SHALL only set their pending bits.
REQ-025 Error flags SHALL clear only on reset.

Reset
REQ-026 Default arbitration (macro undefined) SHALL be fixed priority, lowest index first.
REQ-027 reset SHALL, at the next edge, regardless of state:
- FSM=IDLE; pending, rq_done, mem_req, err_* = 0; rq_dout = 0; round-robin pointer = 0; watchdog = 0.
- An in-flight transaction is abandoned without rq_done.
REQ-028 The first edge after reset deasserts SHALL accept rq_req strobes.

Configuration
REQ-029 SDRAM_ARB_ROUNDROBIN_EN defined: winner SHALL be the first pending index at or after ptr, searching cyclically.
- ptr becomes winner+1 (mod NUM_REQ) at ISSUE.
- Undefined: REQ-026 applies and no pointer register exists.

Structure
REQ-030 Package sdram_arb_pkg SHALL hold:
- the FSM state enum;
- the request-slot struct (addr, din, be, rnw);
- the constants ADDR_W=27 and DATA_W=32.
REQ-031 Winner selection SHALL be a sub-module sdram_arb_pick (pending vector, pointer -> one-hot grant, index), purely combinational.

Verification
REQ-032 Single read: r0 read strobe, addr 0x0001000 -> mem_req 2 cycles later; mem_ready with mem_dout=0xDEADBEEF -> rq_done[0] next cycle, rq_dout=0xDEADBEEF.
REQ-033 Simultaneous strobes on r0, r1, r2 (fixed priority) -> mem order 0,1,2; with SDRAM_ARB_ROUNDROBIN_EN and ptr=1 -> order 1,2,0.
REQ-034 Overrun: r1 strobes twice before its rq_done -> exactly one mem_req for r1 and err_overrun=3'b010.
REQ-035 Timeout: TIMEOUT=8, mem_ready never returned -> rq_done after 8 WAIT cycles with rq_dout=0xFFFFFFFF and err_timeout=1; next pending request issues normally.
REQ-036 Reset mid-WAIT: reset asserted -> mem_req=0, no rq_done, all pending cleared; a mem_ready after reset produces no rq_done.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter.
//   ADDR_W / DATA_W : SDRAM channel address and data widths
//   state_t         : arbiter FSM states
//   slot_t          : one latched request (address, write data, byte enables, direction)
package sdram_arb_pkg;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
        logic [3:0]        be;
        logic              rnw;
    } slot_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Winner selection for the SDRAM port arbiter (purely combinational).
// Searches the pending vector cyclically starting at index ptr and returns the
// first pending requester. With ptr tied to 0 this is fixed priority, lowest
// index first.
//   pending : requesters with a latched, not yet completed request
//   ptr     : index where the search starts
//   grant   : one-hot winner (all zero when nothing is pending)
//   idx     : binary winner index (0 when nothing is pending)
module sdram_arb_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic             found;
    logic [IDX_W-1:0] cand;
    int               pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        pos   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos  = (int'(ptr) + k) % NUM_REQ;
            cand = IDX_W'(pos);
            if (!found && pending[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbitrates NUM_REQ requester ports onto a single 32-bit SDRAM channel with
// at most one transaction outstanding.
//   clk, reset          : single clock, synchronous active-high reset
//   rq_req/addr/din/be/rnw : per-requester request strobe and request fields
//   rq_done, rq_dout    : per-requester completion strobe, shared read data
//   mem_req/addr/din/be/rnw : channel request (mem_req is high for one cycle)
//   mem_ready, mem_dout : channel completion strobe and read data
//   err_overrun         : sticky, a requester strobed while already pending
//   err_timeout         : sticky, the watchdog expired before mem_ready
// Build option: define SDRAM_ARB_ROUNDROBIN_EN for round-robin arbitration;
// otherwise fixed priority (lowest index first) with no pointer register.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        rq_req,
    input  logic [NUM_REQ*ADDR_W-1:0] rq_addr,
    input  logic [NUM_REQ*DATA_W-1:0] rq_din,
    input  logic [NUM_REQ*4-1:0]      rq_be,
    input  logic [NUM_REQ-1:0]        rq_rnw,
    output logic [NUM_REQ-1:0]        rq_done,
    output logic [DATA_W-1:0]         rq_dout,
    output logic                      mem_req,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_din,
    output logic [3:0]                mem_be,
    output logic                      mem_rnw,
    input  logic                      mem_ready,
    input  logic [DATA_W-1:0]         mem_dout,
    output logic [NUM_REQ-1:0]        err_overrun,
    output logic                      err_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 2);

    state_t             state, state_next;
    logic [NUM_REQ-1:0] pending, pending_next, accept, ovr;
    logic [NUM_REQ-1:0] pick_grant, win_oh;
    logic [IDX_W-1:0]   pick_idx, pick_ptr, win_idx;
    logic [WD_W-1:0]    wdog;
    logic               complete, timed_out;
    slot_t              slot [NUM_REQ];
    slot_t              cur;

    // Request capture: a strobe is accepted only when that slot is free, so
    // the winner's slot cannot change while its transaction is in flight.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign accept[g]       = rq_req[g] & ~pending[g];
        assign ovr[g]          = rq_req[g] & pending[g];
        assign pending_next[g] = accept[g] | (pending[g] & ~(complete & win_oh[g]));

        always_ff @(posedge clk) begin
            if (accept[g]) begin
                slot[g] <= '{addr: rq_addr[g*ADDR_W +: ADDR_W],
                             din:  rq_din[g*DATA_W +: DATA_W],
                             be:   rq_be[g*4 +: 4],
                             rnw:  rq_rnw[g]};
            end
        end
    end

`ifdef SDRAM_ARB_ROUNDROBIN_EN
    logic [IDX_W-1:0] ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (state == ISSUE) begin
            ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end
    end

    assign pick_ptr = ptr;
`else
    assign pick_ptr = '0;
`endif

    sdram_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .pending (pending),
        .ptr     (pick_ptr),
        .grant   (pick_grant),
        .idx     (pick_idx)
    );

    // Channel fields come straight from the winner's slot, which is frozen
    // from ISSUE until WAIT exits.
    assign cur      = slot[win_idx];
    assign mem_req  = (state == ISSUE);
    assign mem_addr = cur.addr;
    assign mem_din  = cur.din;
    assign mem_be   = cur.be;
    assign mem_rnw  = cur.rnw;

    // The watchdog holds TIMEOUT in the first WAIT cycle and counts down, so
    // expiry on the value 1 gives exactly TIMEOUT WAIT cycles. mem_ready in
    // the final cycle still counts as a normal completion.
    always_comb begin
        state_next = state;
        complete   = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (|pending) state_next = ISSUE;
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (mem_ready) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (wdog <= WD_W'(1)) begin
                    complete   = 1'b1;
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= '0;
            win_idx     <= '0;
            win_oh      <= '0;
            wdog        <= '0;
            rq_done     <= '0;
            rq_dout     <= '0;
            err_overrun <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            pending     <= pending_next;
            err_overrun <= err_overrun | ovr;
            rq_done     <= complete ? win_oh : '0;

            if (state == IDLE && |pending) begin
                win_idx <= pick_idx;
                win_oh  <= pick_grant;
            end

            if (state == ISSUE) begin
                wdog <= WD_W'(TIMEOUT);
            end else if (complete) begin
                wdog <= '0;
            end else if (state == WAIT) begin
                wdog <= wdog - WD_W'(1);
            end

            if (complete) begin
                rq_dout <= timed_out ? '1 : (cur.rnw ? mem_dout : '0);
            end
            if (timed_out) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter (NUM_REQ=3, TIMEOUT=8).
// Expected channel transactions are queued when requests are driven and
// popped when the arbiter issues them on the channel.
module tb_sdram_port_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [2:0]   rq_req = '0;
    logic [80:0]  rq_addr = '0;
    logic [95:0]  rq_din = '0;
    logic [11:0]  rq_be = '0;
    logic [2:0]   rq_rnw = '0;
    logic [2:0]   rq_done;
    logic [31:0]  rq_dout;
    logic         mem_req;
    logic [26:0]  mem_addr;
    logic [31:0]  mem_din;
    logic [3:0]   mem_be;
    logic         mem_rnw;
    logic         mem_ready = 1'b0;
    logic [31:0]  mem_dout = '0;
    logic [2:0]   err_overrun;
    logic         err_timeout;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [26:0] addr;
        logic [31:0] din;
        logic [3:0]  be;
        logic        rnw;
        int          idx;
        logic [31:0] resp;
    } exp_t;

    exp_t q[$];

    sdram_port_arbiter #(.NUM_REQ(3), .TIMEOUT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .rq_req      (rq_req),
        .rq_addr     (rq_addr),
        .rq_din      (rq_din),
        .rq_be       (rq_be),
        .rq_rnw      (rq_rnw),
        .rq_done     (rq_done),
        .rq_dout     (rq_dout),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_be      (mem_be),
        .mem_rnw     (mem_rnw),
        .mem_ready   (mem_ready),
        .mem_dout    (mem_dout),
        .err_overrun (err_overrun),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [26:0] a, input logic [31:0] d,
                            input logic [3:0] b, input logic r, input logic [31:0] resp,
                            input bit expect_issue);
        exp_t e;
        rq_addr[i*27 +: 27] = a;
        rq_din[i*32 +: 32]  = d;
        rq_be[i*4 +: 4]     = b;
        rq_rnw[i]           = r;
        if (expect_issue) begin
            e.addr = a; e.din = d; e.be = b; e.rnw = r; e.idx = i; e.resp = resp;
            q.push_back(e);
        end
    endtask

    task automatic wait_mem(output int n);
        n = 0;
        while (mem_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Precondition: currently in the ISSUE cycle. Returns in the rq_done cycle.
    task automatic respond(input logic [31:0] d);
        tick();
        mem_ready = 1'b1;
        mem_dout  = d;
        tick();
        mem_ready = 1'b0;
        mem_dout  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests++;
        if (mem_req !== 1'b0 || rq_done !== 3'b000 || rq_dout !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: mem_req=%b rq_done=%b rq_dout=%h want 0/000/0",
                     mem_req, rq_done, rq_dout);
        end
        tests++;
        if (err_overrun !== 3'b000 || err_timeout !== 1'b0) begin
            fails++;
            $display("FAIL reset_errors: err_overrun=%b err_timeout=%b want 000/0",
                     err_overrun, err_timeout);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        int   n;
        exp_t e;
        set_slot(0, 27'h0001000, 32'h0, 4'hF, 1'b1, 32'hDEADBEEF, 1'b1);
        rq_req = 3'b001;
        tick();
        rq_req = 3'b000;
        wait_mem(n);
        tests++;
        if (mem_req !== 1'b1 || n != 1) begin
            fails++;
            $display("FAIL single_latency: mem_req=%b after %0d extra cycles, want 1 after 1", mem_req, n);
        end
        e = q.pop_front();
        tests++;
        if (mem_addr !== e.addr || mem_rnw !== e.rnw || mem_be !== e.be) begin
            fails++;
            $display("FAIL single_fields: addr=%h rnw=%b be=%h want %h %b %h",
                     mem_addr, mem_rnw, mem_be, e.addr, e.rnw, e.be);
        end
        tick();
        tests++;
        if (mem_req !== 1'b0 || mem_addr !== e.addr || rq_done !== 3'b000) begin
            fails++;
            $display("FAIL wait_hold: mem_req=%b addr=%h rq_done=%b want 0 %h 000",
                     mem_req, mem_addr, rq_done, e.addr);
        end
        mem_ready = 1'b1;
        mem_dout  = e.resp;
        tick();
        mem_ready = 1'b0;
        mem_dout  = '0;
        tests++;
        if (rq_done !== 3'b001 || rq_dout !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL single_done: rq_done=%b rq_dout=%h want 001 deadbeef", rq_done, rq_dout);
        end
    endtask

    task automatic test_priority();
        int         n;
        exp_t       e;
        logic [2:0] oh;
        logic [31:0] want;
`ifdef SDRAM_ARB_ROUNDROBIN_EN
        // The pointer sits at 1 after requester 0 won the previous transaction.
        set_slot(1, 27'h4000200, 32'h22222222, 4'h3, 1'b0, 32'hBBBB0001, 1'b1);
        set_slot(2, 27'h0000300, 32'h33333333, 4'hC, 1'b1, 32'hCCCC0002, 1'b1);
        set_slot(0, 27'h0000100, 32'h11111111, 4'hF, 1'b1, 32'hAAAA0000, 1'b1);
`else
        set_slot(0, 27'h0000100, 32'h11111111, 4'hF, 1'b1, 32'hAAAA0000, 1'b1);
        set_slot(1, 27'h4000200, 32'h22222222, 4'h3, 1'b0, 32'hBBBB0001, 1'b1);
        set_slot(2, 27'h0000300, 32'h33333333, 4'hC, 1'b1, 32'hCCCC0002, 1'b1);
`endif
        rq_req = 3'b111;
        tick();
        rq_req = 3'b000;
        for (int k = 0; k < 3; k++) begin
            wait_mem(n);
            e = q.pop_front();
            tests++;
            if (mem_req !== 1'b1 || mem_addr !== e.addr || mem_din !== e.din ||
                mem_be !== e.be || mem_rnw !== e.rnw) begin
                fails++;
                $display("FAIL prio_order%0d: req=%b addr=%h din=%h be=%h rnw=%b want req %0d addr=%h",
                         k, mem_req, mem_addr, mem_din, mem_be, mem_rnw, e.idx, e.addr);
            end
            respond(e.resp);
            oh   = 3'b001 << e.idx;
            want = e.rnw ? e.resp : 32'h0;
            tests++;
            if (rq_done !== oh || rq_dout !== want) begin
                fails++;
                $display("FAIL prio_done%0d: rq_done=%b rq_dout=%h want %b %h", k, rq_done, rq_dout, oh, want);
            end
        end
        tests++;
        if (err_overrun !== 3'b000) begin
            fails++;
            $display("FAIL prio_no_overrun: err_overrun=%b want 000", err_overrun);
        end
    endtask

    task automatic test_overrun();
        int   n;
        int   extra;
        exp_t e;
        set_slot(1, 27'h0002220, 32'h5A5A5A5A, 4'h1, 1'b0, 32'h12345678, 1'b1);
        rq_req = 3'b010;
        tick();
        set_slot(1, 27'h0007770, 32'hA5A5A5A5, 4'h8, 1'b1, 32'h0, 1'b0);
        tick();
        rq_req = 3'b000;
        wait_mem(n);
        e = q.pop_front();
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== e.addr || mem_din !== e.din || mem_rnw !== e.rnw) begin
            fails++;
            $display("FAIL overrun_fields: req=%b addr=%h din=%h rnw=%b want 1 %h %h %b",
                     mem_req, mem_addr, mem_din, mem_rnw, e.addr, e.din, e.rnw);
        end
        respond(e.resp);
        tests++;
        if (rq_done !== 3'b010 || rq_dout !== 32'h0) begin
            fails++;
            $display("FAIL overrun_done: rq_done=%b rq_dout=%h want 010 0", rq_done, rq_dout);
        end
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (mem_req === 1'b1) extra++;
        end
        tests++;
        if (extra != 0 || err_overrun !== 3'b010) begin
            fails++;
            $display("FAIL overrun_flag: extra mem_req=%0d err_overrun=%b want 0 010", extra, err_overrun);
        end
    endtask

    task automatic test_back_to_back();
        int   n;
        exp_t e;
        set_slot(0, 27'h0010000, 32'h0, 4'hF, 1'b1, 32'h0BADF00D, 1'b1);
        rq_req = 3'b001;
        tick();
        rq_req = 3'b000;
        wait_mem(n);
        e = q.pop_front();
        respond(e.resp);
        tests++;
        if (rq_done !== 3'b001 || rq_dout !== 32'h0BADF00D) begin
            fails++;
            $display("FAIL b2b_first_done: rq_done=%b rq_dout=%h want 001 0badf00d", rq_done, rq_dout);
        end
        // New strobe from the same requester in its own done cycle.
        set_slot(0, 27'h0020004, 32'h0, 4'h6, 1'b1, 32'hFEEDC0DE, 1'b1);
        rq_req = 3'b001;
        tick();
        rq_req = 3'b000;
        tests++;
        if (err_overrun !== 3'b010) begin
            fails++;
            $display("FAIL b2b_accept: err_overrun=%b want 010", err_overrun);
        end
        wait_mem(n);
        e = q.pop_front();
        tests++;
        if (mem_req !== 1'b1 || n != 1 || mem_addr !== e.addr || mem_be !== e.be) begin
            fails++;
            $display("FAIL b2b_issue: req=%b extra=%0d addr=%h be=%h want 1 1 %h %h",
                     mem_req, n, mem_addr, mem_be, e.addr, e.be);
        end
        respond(e.resp);
        tests++;
        if (rq_done !== 3'b001 || rq_dout !== 32'hFEEDC0DE) begin
            fails++;
            $display("FAIL b2b_second_done: rq_done=%b rq_dout=%h want 001 feedc0de", rq_done, rq_dout);
        end
    endtask

    task automatic test_timeout();
        int   n;
        exp_t e;
        set_slot(2, 27'h4001230, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1);
        rq_req = 3'b100;
        tick();
        set_slot(0, 27'h0003450, 32'h0, 4'hF, 1'b1, 32'h600DD00D, 1'b1);
        rq_req = 3'b001;
        tick();
        rq_req = 3'b000;
        wait_mem(n);
        e = q.pop_front();
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== e.addr) begin
            fails++;
            $display("FAIL timeout_issue: req=%b addr=%h want 1 %h", mem_req, mem_addr, e.addr);
        end
        n = 0;
        while (rq_done === 3'b000 && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (n != 9 || rq_done !== 3'b100 || rq_dout !== 32'hFFFFFFFF) begin
            fails++;
            $display("FAIL timeout_done: after %0d cycles rq_done=%b rq_dout=%h want 9 100 ffffffff",
                     n, rq_done, rq_dout);
        end
        tests++;
        if (err_timeout !== 1'b1) begin
            fails++;
            $display("FAIL timeout_flag: err_timeout=%b want 1", err_timeout);
        end
        // Late mem_ready outside WAIT must be ignored.
        mem_ready = 1'b1;
        mem_dout  = 32'h99999999;
        tick();
        mem_ready = 1'b0;
        mem_dout  = '0;
        e = q.pop_front();
        tests++;
        if (rq_done !== 3'b000 || mem_req !== 1'b1 || mem_addr !== e.addr) begin
            fails++;
            $display("FAIL timeout_next: rq_done=%b req=%b addr=%h want 000 1 %h",
                     rq_done, mem_req, mem_addr, e.addr);
        end
        respond(e.resp);
        tests++;
        if (rq_done !== 3'b001 || rq_dout !== 32'h600DD00D) begin
            fails++;
            $display("FAIL timeout_next_done: rq_done=%b rq_dout=%h want 001 600dd00d", rq_done, rq_dout);
        end
    endtask

    task automatic test_reset_mid_wait();
        int   n;
        int   extra;
        exp_t e;
        set_slot(0, 27'h0000040, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1);
        set_slot(1, 27'h0000080, 32'h0, 4'hF, 1'b1, 32'h0, 1'b0);
        rq_req = 3'b011;
        tick();
        rq_req = 3'b000;
        wait_mem(n);
        e = q.pop_front();
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== e.addr || err_timeout !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre: req=%b addr=%h err_timeout=%b want 1 %h 1",
                     mem_req, mem_addr, err_timeout, e.addr);
        end
        tick();
        reset = 1'b1;
        tick();
        tests++;
        if (mem_req !== 1'b0 || rq_done !== 3'b000 || rq_dout !== 32'h0 ||
            err_overrun !== 3'b000 || err_timeout !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_wait: req=%b done=%b dout=%h ovr=%b tmo=%b want all 0",
                     mem_req, rq_done, rq_dout, err_overrun, err_timeout);
        end
        // Release reset with a stale mem_ready and a fresh strobe on the same edge.
        reset     = 1'b0;
        mem_ready = 1'b1;
        mem_dout  = 32'h77777777;
        set_slot(2, 27'h0000C00, 32'h0, 4'hF, 1'b1, 32'hC0FFEE00, 1'b1);
        rq_req = 3'b100;
        tick();
        rq_req    = 3'b000;
        mem_ready = 1'b0;
        mem_dout  = '0;
        tests++;
        if (rq_done !== 3'b000 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL rst_late_ready: rq_done=%b mem_req=%b want 000 0", rq_done, mem_req);
        end
        tick();
        e = q.pop_front();
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== e.addr) begin
            fails++;
            $display("FAIL rst_first_edge: req=%b addr=%h want 1 %h", mem_req, mem_addr, e.addr);
        end
        respond(e.resp);
        tests++;
        if (rq_done !== 3'b100 || rq_dout !== 32'hC0FFEE00) begin
            fails++;
            $display("FAIL rst_after_done: rq_done=%b rq_dout=%h want 100 c0ffee00", rq_done, rq_dout);
        end
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (mem_req === 1'b1 || rq_done !== 3'b000) extra++;
        end
        tests++;
        if (extra != 0) begin
            fails++;
            $display("FAIL rst_pending_cleared: %0d unexpected cycles with activity, want 0", extra);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_overrun();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_empty: %0d entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
